mul_div_unit: RTL and testbench

Multi-cycle signed multiply/divide engine for the ezRISC datapath. It executes the ALU control codes the combinational ALU leaves unimplemented: mul (4'b1000) and div (4'b1001). It takes the same operands, the Y register value and the bus value, and produces a 64-bit result that is written into the Z register pair (ZHI/ZLO). The control sequencer starts it with a one-cycle pulse and waits for `done` before strobing Z.

---
 rtl/ezrisc_pkg.sv | 23 ++
 rtl/mul_div_unit.sv | 156 +++++++++++++++
 tb/tb_mul_div_unit.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/ezrisc_pkg.sv
// Shared ezRISC definitions: ALU control codes and the multiply/divide unit state type.
package ezrisc_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0011;
    localparam logic [3:0] ALU_SHR = 4'b0100;
    localparam logic [3:0] ALU_SHL = 4'b0101;
    localparam logic [3:0] ALU_ROR = 4'b0110;
    localparam logic [3:0] ALU_ROL = 4'b0111;
    localparam logic [3:0] ALU_MUL = 4'b1000;
    localparam logic [3:0] ALU_DIV = 4'b1001;
    localparam logic [3:0] ALU_NEG = 4'b1010;
    localparam logic [3:0] ALU_NOT = 4'b1011;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } mdu_state_t;

endpackage

// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) and restoring divide for the ezRISC datapath.
// One shared shift register, one adder/subtractor and one iteration counter serve both ops.
module mul_div_unit
    import ezrisc_pkg::*;
#(
    parameter int unsigned REG_SIZE = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [3:0]              ctrl_sig,
    input  logic [REG_SIZE-1:0]     y_data_in,
    input  logic [REG_SIZE-1:0]     bus_data_in,
    output logic [2*REG_SIZE-1:0]   z_data_out,
    output logic                    busy,
    output logic                    done,
    output logic                    div_by_zero
);

    localparam int unsigned N  = REG_SIZE;
    localparam int unsigned AW = 2 * N + 1;

    mdu_state_t     state;
    logic [5:0]     cnt;
    logic           is_div;
    logic           q_neg;
    logic           r_neg;
    logic           dbz;
    logic [N-1:0]   opb;
    logic [AW-1:0]  acc;

    logic           req_valid;
    logic           req_div;
    logic           req_dbz;
    logic [N:0]     add_a;
    logic [N:0]     add_b;
    logic [N:0]     add_sum;
    logic           add_sub;
    logic [N:0]     div_r;
    logic [AW-1:0]  acc_next;
    logic [N-1:0]   q_fix;
    logic [N-1:0]   r_fix;
    logic [2*N-1:0] z_fix;

    function automatic logic [N-1:0] mag(input logic [N-1:0] v);
        return v[N-1] ? (~v + 1'b1) : v;
    endfunction

    assign req_div   = (ctrl_sig == ALU_DIV);
    assign req_valid = (ctrl_sig == ALU_MUL) || req_div;
    assign req_dbz   = req_div && (bus_data_in == '0);

    // Divide: {R, Q} shifted left by one before the trial subtraction.
    assign div_r = {acc[2*N-1:N], acc[N-1]};

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_sub = 1'b0;
        if (is_div) begin
            add_a   = div_r;
            add_b   = {1'b0, opb};
            add_sub = 1'b1;
        end else begin
            add_a   = {acc[2*N], acc[2*N:N+1]};
            add_b   = (acc[1] ^ acc[0]) ? {opb[N-1], opb} : '0;
            add_sub = (acc[1:0] == 2'b10);
        end
        add_sum = add_sub ? (add_a - add_b) : (add_a + add_b);
    end

    always_comb begin
        acc_next = acc;
        if (is_div) begin
            if (!add_sum[N]) begin
                acc_next = {add_sum, acc[N-2:0], 1'b1};
            end else begin
                acc_next = {div_r, acc[N-2:0], 1'b0};
            end
        end else begin
            // N+1-bit sum then arithmetic shift: A may transiently need the extra bit.
            acc_next = {add_sum, acc[N:1]};
        end
    end

    always_comb begin
        q_fix = q_neg ? (~acc[N-1:0] + 1'b1) : acc[N-1:0];
        r_fix = r_neg ? (~acc[2*N-1:N] + 1'b1) : acc[2*N-1:N];
        if (dbz) begin
            z_fix = {acc[N-1:0], {N{1'b1}}};
        end else if (is_div) begin
            z_fix = {r_fix, q_fix};
        end else begin
            z_fix = acc[2*N:1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            is_div      <= 1'b0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            dbz         <= 1'b0;
            opb         <= '0;
            acc         <= '0;
            z_data_out  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start && req_valid) begin
                        is_div      <= req_div;
                        dbz         <= req_dbz;
                        q_neg       <= y_data_in[N-1] ^ bus_data_in[N-1];
                        r_neg       <= y_data_in[N-1];
                        cnt         <= '0;
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                        if (req_div) begin
                            // Divide by zero keeps the raw dividend for the remainder field.
                            acc   <= {{(N+1){1'b0}}, req_dbz ? y_data_in : mag(y_data_in)};
                            opb   <= mag(bus_data_in);
                            state <= req_dbz ? FIX : RUN;
                        end else begin
                            acc   <= {{N{1'b0}}, bus_data_in, 1'b0};
                            opb   <= y_data_in;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'(N - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    z_data_out  <= z_fix;
                    div_by_zero <= dbz;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    cnt         <= '0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit with hand-computed results.
module tb_mul_div_unit;

    localparam int unsigned RS = 32;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [3:0]      ctrl_sig;
    logic [RS-1:0]   y_data_in;
    logic [RS-1:0]   bus_data_in;
    logic [2*RS-1:0] z_data_out;
    logic            busy;
    logic            done;
    logic            div_by_zero;

    int n_cmp;
    int n_err;
    int n_edges;
    int n_done;

    mul_div_unit #(.REG_SIZE(RS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .ctrl_sig    (ctrl_sig),
        .y_data_in   (y_data_in),
        .bus_data_in (bus_data_in),
        .z_data_out  (z_data_out),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives a one-cycle request and returns #1 after the accepting edge.
    task automatic start_op(input logic [3:0] op, input logic [31:0] y, input logic [31:0] b);
        start       = 1'b1;
        ctrl_sig    = op;
        y_data_in   = y;
        bus_data_in = b;
        @(posedge clk);
        #1;
        start       = 1'b0;
        y_data_in   = 32'hDEAD_BEEF;
        bus_data_in = 32'h1234_5678;
    endtask

    // Counts edges until done is seen (bounded); returns inside the done cycle.
    task automatic wait_done(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] y,
                          input logic [31:0] b, input logic [63:0] exp_z, input int exp_lat,
                          input logic exp_dbz);
        int n;
        start_op(op, y, b);
        chk({tag, "_busy_start"}, 64'(busy), 64'd1);
        wait_done(n);
        chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
        chk({tag, "_z"}, z_data_out, exp_z);
        chk({tag, "_busy_done"}, 64'(busy), 64'd0);
        chk({tag, "_dbz"}, 64'(div_by_zero), 64'(exp_dbz));
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        ctrl_sig    = 4'b0000;
        y_data_in   = '0;
        bus_data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_z", z_data_out, 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_dbz", 64'(div_by_zero), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("mul_7_m3", 4'b1000, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 33, 1'b0);
        run_op("mul_min_min", 4'b1000, 32'h8000_0000, 32'h8000_0000,
               64'h4000_0000_0000_0000, 33, 1'b0);
        run_op("mul_max_max", 4'b1000, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
               64'h3FFF_FFFF_0000_0001, 33, 1'b0);
        run_op("mul_m100_5", 4'b1000, 32'hFFFF_FF9C, 32'd5, 64'hFFFF_FFFF_FFFF_FE0C, 33, 1'b0);
        run_op("div_m7_2", 4'b1001, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33, 1'b0);
        run_op("div_100_7", 4'b1001, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 33, 1'b0);
        run_op("div_7_m2", 4'b1001, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 33, 1'b0);
        run_op("div_100_0", 4'b1001, 32'd100, 32'd0, 64'h0000_0064_FFFF_FFFF, 1, 1'b1);

        // Flag clears at the next accepted start; this op is also the overflow case.
        start_op(4'b1001, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("dbz_cleared", 64'(div_by_zero), 64'd0);
        wait_done(n_edges);
        chk("div_ovf_latency", 64'(n_edges), 64'd33);
        chk("div_ovf_z", z_data_out, 64'h0000_0000_8000_0000);
        chk("div_ovf_dbz", 64'(div_by_zero), 64'd0);

        // A second start mid-operation is ignored.
        start_op(4'b1000, 32'd7, 32'hFFFF_FFFD);
        repeat (9) @(posedge clk);
        #1;
        start       = 1'b1;
        ctrl_sig    = 4'b1001;
        y_data_in   = 32'd100;
        bus_data_in = 32'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n_edges);
        chk("ignore_latency", 64'(n_edges), 64'd23);
        chk("ignore_z", z_data_out, 64'hFFFF_FFFF_FFFF_FFEB);
        chk("ignore_dbz", 64'(div_by_zero), 64'd0);

        // Invalid opcode in IDLE does nothing.
        @(posedge clk);
        #1;
        start_op(4'b0010, 32'd3, 32'd4);
        chk("invalid_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        chk("invalid_done", 64'(done), 64'd0);
        chk("invalid_z", z_data_out, 64'hFFFF_FFFF_FFFF_FFEB);

        // Reset in the middle of a multiply.
        start_op(4'b1000, 32'd100, 32'd100);
        repeat (11) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_z", z_data_out, 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        chk("abort_no_done", 64'(n_done), 64'd0);
        chk("abort_busy_after", 64'(busy), 64'd0);

        run_op("after_reset", 4'b1000, 32'd100, 32'd100, 64'h0000_0000_0000_2710, 33, 1'b0);

        // Back-to-back: start issued in the done cycle of the previous op.
        run_op("b2b_div", 4'b1001, 32'd100, 32'd0, 64'h0000_0064_FFFF_FFFF, 1, 1'b1);
        run_op("b2b_mul", 4'b1000, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 33, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
